// File: rtl/tdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdc_pkg : shared FSM encoding, readout codes and width helpers for   |
// |           the TDC sampler.                                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_CAP  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } tdc_state_e;

  localparam logic [1:0] C_OSEL_AVG    = 2'b00;
  localparam logic [1:0] C_OSEL_ACC_LO = 2'b01;
  localparam logic [1:0] C_OSEL_ACC_HI = 2'b10;
  localparam logic [1:0] C_OSEL_STATUS = 2'b11;

  // Sample counter must hold 2^7 = 128.
  localparam int C_SMP_W    = 8;
  localparam int C_N_LOG2_W = 3;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_therm_count.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdc_therm_count : popcount and bubble detection for one tap snapshot |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdc_therm_count
  import tdc_pkg::*;
#(
  parameter int TAP_W = 19,
  parameter int CNT_W = clog2_min1(TAP_W + 1)
) (
  input  logic [TAP_W-1:0] taps,
  output logic [CNT_W-1:0] count,
  output logic             bubble
);

  logic [CNT_W-1:0] w_trans;

  // A clean thermometer code has at most one 0/1 boundary.
  always_comb begin
    count   = '0;
    w_trans = '0;
    for (int i = 0; i < TAP_W; i++) begin
      count = count + CNT_W'(taps[i]);
    end
    for (int i = 0; i < TAP_W - 1; i++) begin
      w_trans = w_trans + CNT_W'(taps[i] ^ taps[i+1]);
    end
    bubble = (w_trans > CNT_W'(1));
  end

endmodule
`default_nettype wire

// File: rtl/tdc_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdc_sampler : ring-oscillator TDC capture, averaging and byte readout|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdc_sampler
  import tdc_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int TAP_W  = 19,
  parameter int SETTLE = 4,
  parameter int SEL_W  = clog2_min1(N_CH),
  parameter int CNT_W  = clog2_min1(TAP_W + 1),
  parameter int ACC_W  = CNT_W + 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ro_deactivate,
  input  logic [SEL_W-1:0]        ch_sel,
  input  logic [C_N_LOG2_W-1:0]   n_log2,
  input  logic [1:0]              out_sel,
  input  logic [N_CH*TAP_W-1:0]   taps_in,
  output logic                    ro_activate,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              out
);

  localparam int               TMR_W      = clog2_min1(SETTLE);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(SETTLE - 1);

  tdc_state_e                r_state;
  tdc_state_e                w_state_next;
  logic [TMR_W-1:0]          r_tmr;
  logic [C_SMP_W-1:0]        r_smp;
  logic [C_SMP_W-1:0]        w_smp_target;
  logic [SEL_W-1:0]          r_ch;
  logic [C_N_LOG2_W-1:0]     r_n;
  logic [ACC_W-1:0]          r_acc_work;
  logic [ACC_W-1:0]          r_acc;
  logic [ACC_W-1:0]          r_avg;
  logic                      r_err;
  logic [7:0]                r_out;
  logic [N_CH*TAP_W-1:0]     r_taps_meta;
  logic [N_CH*TAP_W-1:0]     r_taps_sync;
  logic [TAP_W-1:0]          w_ch_arr [N_CH];
  logic [TAP_W-1:0]          w_sel_taps;
  logic [CNT_W-1:0]          w_count;
  logic                      w_bubble;
  logic                      w_tmr_done;
  logic                      w_busy;

  // Every tap crosses into clk through two flops, regardless of channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taps_meta <= '0;
      r_taps_sync <= '0;
    end else begin
      r_taps_meta <= taps_in;
      r_taps_sync <= r_taps_meta;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch_unpack
    assign w_ch_arr[g] = r_taps_sync[g*TAP_W +: TAP_W];
  end

  // Out-of-range channels read as all-zero, giving a count of 0.
  always_comb begin
    w_sel_taps = '0;
    if (int'(r_ch) < N_CH) begin
      w_sel_taps = w_ch_arr[r_ch];
    end
  end

  tdc_therm_count #(
    .TAP_W (TAP_W),
    .CNT_W (CNT_W)
  ) u_therm_count (
    .taps   (w_sel_taps),
    .count  (w_count),
    .bubble (w_bubble)
  );

  assign w_tmr_done   = (r_tmr == C_TMR_LAST);
  assign w_smp_target = C_SMP_W'(1) << r_n;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_ARM;
      ST_ARM:  if (w_tmr_done) w_state_next = ST_CAP;
      ST_CAP:  w_state_next = ST_GAP;
      ST_GAP: begin
        if (w_tmr_done) begin
          w_state_next = (r_smp == w_smp_target) ? ST_DONE : ST_ARM;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (ro_deactivate) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr      <= '0;
      r_smp      <= '0;
      r_ch       <= '0;
      r_n        <= '0;
      r_acc_work <= '0;
      r_acc      <= '0;
      r_avg      <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || !((r_state == ST_ARM) || (r_state == ST_GAP))) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + TMR_W'(1);
      end

      if ((r_state == ST_IDLE) && (w_state_next == ST_ARM)) begin
        r_ch       <= ch_sel;
        r_n        <= n_log2;
        r_acc_work <= '0;
        r_smp      <= '0;
        r_err      <= 1'b0;
      end

      // An abort during CAP discards that sample entirely.
      if ((r_state == ST_CAP) && (w_state_next == ST_GAP)) begin
        r_acc_work <= r_acc_work + ACC_W'(w_count);
        r_err      <= r_err | w_bubble;
        r_smp      <= r_smp + C_SMP_W'(1);
      end

      // Snapshot on entry to DONE so the readout is current one cycle after done.
      if ((r_state == ST_GAP) && (w_state_next == ST_DONE)) begin
        r_acc <= r_acc_work;
        r_avg <= r_acc_work >> r_n;
      end
    end
  end

  assign w_busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 8'h00;
    end else begin
      case (out_sel)
        C_OSEL_AVG:    r_out <= 8'(r_avg);
        C_OSEL_ACC_LO: r_out <= r_acc[7:0];
        C_OSEL_ACC_HI: r_out <= 8'(r_acc >> 8);
        C_OSEL_STATUS: r_out <= {w_busy, r_err, 6'b0};
        default:       r_out <= 8'h00;
      endcase
    end
  end

  assign ro_activate = (r_state == ST_ARM) || (r_state == ST_CAP);
  assign busy        = w_busy;
  assign done        = (r_state == ST_DONE);
  assign out         = r_out;

endmodule
`default_nettype wire

// File: tb/tb_tdc_sampler.sv
`default_nettype none
// Bench for tdc_sampler: directed scenarios plus randomized measurements
// compared against an arithmetic model of the averaging rules.
module tb_tdc_sampler;

  localparam int N_CH   = 8;
  localparam int TAP_W  = 19;
  localparam int SETTLE = 4;
  localparam int SAMPLE_CYC = 2 * SETTLE + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  ro_deactivate;
  logic [2:0]            ch_sel;
  logic [2:0]            n_log2;
  logic [1:0]            out_sel;
  logic [N_CH*TAP_W-1:0] taps_in;
  logic                  ro_activate;
  logic                  busy;
  logic                  done;
  logic [7:0]            out;

  int checks = 0;
  int passes = 0;

  logic [TAP_W-1:0] samp [128];
  int               lat;
  bit               tmo;
  int               exp_acc;
  int               exp_avg;
  bit               exp_err;
  logic [7:0]       rd_avg, rd_lo, rd_hi, rd_st;

  tdc_sampler #(
    .N_CH   (N_CH),
    .TAP_W  (TAP_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ro_deactivate (ro_deactivate),
    .ch_sel        (ch_sel),
    .n_log2        (n_log2),
    .out_sel       (out_sel),
    .taps_in       (taps_in),
    .ro_activate   (ro_activate),
    .busy          (busy),
    .done          (done),
    .out           (out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_bubble(input logic [TAP_W-1:0] v);
    logic [TAP_W-2:0] d;
    d = v[TAP_W-2:0] ^ v[TAP_W-1:1];
    return $countones(d) > 1;
  endfunction

  task automatic model(input int ch, input int n);
    exp_acc = 0;
    exp_err = 0;
    for (int i = 0; i < (1 << n); i++) begin
      if (ch < N_CH) begin
        exp_acc += $countones(samp[i]);
        if (model_bubble(samp[i])) exp_err = 1;
      end
    end
    exp_avg = exp_acc / (1 << n);
  endtask

  task automatic drive_taps(input int ch, input logic [TAP_W-1:0] v);
    for (int c = 0; c < N_CH; c++) begin
      taps_in[c*TAP_W +: TAP_W] = (c == ch) ? v : TAP_W'($urandom);
    end
  endtask

  function automatic logic [TAP_W-1:0] therm(input int k);
    logic [TAP_W:0] w;
    w = (20'd1 << k) - 20'd1;
    return w[TAP_W-1:0];
  endfunction

  // Starts a measurement, feeds samp[i] as the channel taps for sample i,
  // and returns in the done cycle with lat = cycle index of done.
  task automatic run_meas(input int ch, input int n);
    int   sidx;
    logic prev;
    drive_taps(ch, samp[0]);
    @(posedge clk); #1;
    start = 1; ch_sel = ch[2:0]; n_log2 = n[2:0];
    @(posedge clk); #1;
    start = 0; ch_sel = 3'($urandom); n_log2 = 3'($urandom);
    lat = 1; sidx = 0; prev = ro_activate; tmo = 0;
    while (done !== 1'b1) begin
      if (lat > 2000) begin tmo = 1; break; end
      @(posedge clk); #1;
      lat++;
      if (prev && !ro_activate) begin
        sidx++;
        if (sidx < (1 << n)) drive_taps(ch, samp[sidx]);
      end
      prev = ro_activate;
    end
  endtask

  task automatic read_sel(input logic [1:0] s, output logic [7:0] v);
    out_sel = s;
    @(posedge clk); #1;
    v = out;
  endtask

  task automatic read_all();
    read_sel(2'b00, rd_avg);
    read_sel(2'b01, rd_lo);
    read_sel(2'b10, rd_hi);
    read_sel(2'b11, rd_st);
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; ro_deactivate = 0; ch_sel = 0; n_log2 = 0;
    out_sel = 0; taps_in = '0;
    #23;
    checks++;
    if ({ro_activate, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {ro_activate, busy, done});
    else passes++;
    checks++;
    if (out !== 8'h00) $display("FAIL reset_out: got %h expected 00", out);
    else passes++;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [2:0] exp;
    drive_taps(3, 19'h000FF);
    @(posedge clk); #1;
    start = 1; ch_sel = 3; n_log2 = 0;
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k <= 11; k++) begin
      exp = {(k <= 5), (k <= 10), (k == 10)};
      checks++;
      if ({ro_activate, busy, done} !== exp)
        $display("FAIL single_timing cycle %0d: got %b expected %b", k, {ro_activate, busy, done}, exp);
      else passes++;
      @(posedge clk); #1;
    end
    read_all();
    checks++;
    if (rd_avg !== 8'h08) $display("FAIL single_avg: got %h expected 08", rd_avg);
    else passes++;
    checks++;
    if (rd_st !== 8'h00) $display("FAIL single_status: got %h expected 00", rd_st);
    else passes++;
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) samp[i] = (i % 2 == 0) ? 19'h0000F : 19'h0003F;
    run_meas(0, 2);
    model(0, 2);
    checks++;
    if (tmo || lat != 4 * SAMPLE_CYC + 1) $display("FAIL alt_latency: got %0d expected %0d", lat, 4 * SAMPLE_CYC + 1);
    else passes++;
    read_all();
    checks++;
    if (rd_lo !== 8'h14 || rd_lo !== 8'(exp_acc)) $display("FAIL alt_acc_lo: got %h expected 14", rd_lo);
    else passes++;
    checks++;
    if (rd_avg !== 8'h05) $display("FAIL alt_avg: got %h expected 05", rd_avg);
    else passes++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 128; i++) samp[i] = '1;
    run_meas(5, 7);
    checks++;
    if (tmo || lat != 128 * SAMPLE_CYC + 1) $display("FAIL full_latency: got %0d expected %0d", lat, 128 * SAMPLE_CYC + 1);
    else passes++;
    read_all();
    checks++;
    if (rd_lo !== 8'h80) $display("FAIL full_acc_lo: got %h expected 80", rd_lo);
    else passes++;
    checks++;
    if (rd_hi !== 8'h09) $display("FAIL full_acc_hi: got %h expected 09", rd_hi);
    else passes++;
    checks++;
    if (rd_avg !== 8'd19) $display("FAIL full_avg: got %h expected 13", rd_avg);
    else passes++;
  endtask

  task automatic test_bubble();
    int bi;
    bi = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) samp[i] = (i == bi) ? 19'h00F0F : therm($urandom_range(0, 19));
    run_meas(6, 2);
    model(6, 2);
    read_all();
    checks++;
    if (rd_st !== 8'h40) $display("FAIL bubble_status: got %h expected 40", rd_st);
    else passes++;
    checks++;
    if (rd_lo !== 8'(exp_acc)) $display("FAIL bubble_acc_lo: got %h expected %h", rd_lo, 8'(exp_acc));
    else passes++;
    // fresh measurement must clear err as soon as it starts
    samp[0] = 19'h0007F;
    drive_taps(2, samp[0]);
    out_sel = 2'b11;
    @(posedge clk); #1;
    start = 1; ch_sel = 2; n_log2 = 0;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    checks++;
    if (out !== 8'h80) $display("FAIL err_clear: got %h expected 80", out);
    else passes++;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    read_all();
    checks++;
    if (rd_avg !== 8'h07 || rd_st !== 8'h00) $display("FAIL clean_after_bubble: got avg %h st %h expected 07 00", rd_avg, rd_st);
    else passes++;
  endtask

  task automatic test_abort();
    int  falls;
    bit  saw_done;
    logic prev;
    for (int i = 0; i < 4; i++) samp[i] = '1;
    drive_taps(1, samp[0]);
    @(posedge clk); #1;
    start = 1; ch_sel = 1; n_log2 = 2;
    @(posedge clk); #1;
    start = 0;
    falls = 0; prev = ro_activate; lat = 0;
    while (falls < 2 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (prev && !ro_activate) falls++;
      prev = ro_activate;
    end
    ro_deactivate = 1;
    @(posedge clk); #1;
    ro_deactivate = 0;
    checks++;
    if ({ro_activate, busy} !== 2'b00) $display("FAIL abort_idle: got %b expected 00", {ro_activate, busy});
    else passes++;
    saw_done = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) $display("FAIL abort_no_done: got activity expected none");
    else passes++;
    read_all();
    checks++;
    if (rd_avg !== 8'h07 || rd_lo !== 8'h07) $display("FAIL abort_hold: got avg %h lo %h expected 07 07", rd_avg, rd_lo);
    else passes++;
  endtask

  task automatic test_ignore();
    samp[0] = 19'h001FF;
    drive_taps(1, samp[0]);
    @(posedge clk); #1;
    start = 1; ch_sel = 1; n_log2 = 0;
    @(posedge clk); #1;
    start = 0; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) begin start = 1; ch_sel = 4; n_log2 = 3; end
      if (lat == 3) start = 0;
    end
    checks++;
    if (lat != SAMPLE_CYC + 1) $display("FAIL ignore_latency: got %0d expected %0d", lat, SAMPLE_CYC + 1);
    else passes++;
    read_sel(2'b00, rd_avg);
    checks++;
    if (rd_avg !== 8'h09) $display("FAIL ignore_avg: got %h expected 09", rd_avg);
    else passes++;
    // start and abort together in IDLE: abort wins
    start = 1; ro_deactivate = 1;
    @(posedge clk); #1;
    start = 0; ro_deactivate = 0;
    checks++;
    if ({ro_activate, busy} !== 2'b00) $display("FAIL start_vs_abort: got %b expected 00", {ro_activate, busy});
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({ro_activate, busy} !== 2'b00) $display("FAIL start_vs_abort_late: got %b expected 00", {ro_activate, busy});
    else passes++;
  endtask

  task automatic test_random();
    int ch, n;
    for (int it = 0; it < 10; it++) begin
      ch = $urandom_range(0, N_CH - 1);
      n  = $urandom_range(0, 3);
      for (int i = 0; i < (1 << n); i++) begin
        samp[i] = ($urandom_range(0, 3) == 0) ? TAP_W'($urandom) : therm($urandom_range(0, TAP_W));
      end
      run_meas(ch, n);
      model(ch, n);
      checks++;
      if (tmo || lat != (1 << n) * SAMPLE_CYC + 1)
        $display("FAIL rand_latency it %0d: got %0d expected %0d", it, lat, (1 << n) * SAMPLE_CYC + 1);
      else passes++;
      read_all();
      checks++;
      if ({rd_avg, rd_lo, rd_hi, rd_st} !== {8'(exp_avg), 8'(exp_acc), 8'(exp_acc >> 8), 1'b0, exp_err, 6'b0})
        $display("FAIL rand_result it %0d ch %0d n %0d: got %h %h %h %h expected %h %h %h %h", it, ch, n,
                 rd_avg, rd_lo, rd_hi, rd_st, 8'(exp_avg), 8'(exp_acc), 8'(exp_acc >> 8), {1'b0, exp_err, 6'b0});
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    samp[0] = '1; samp[1] = '1;
    drive_taps(4, samp[0]);
    out_sel = 2'b11;
    @(posedge clk); #1;
    start = 1; ch_sel = 4; n_log2 = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ro_activate, busy, done, out} !== 11'd0)
      $display("FAIL async_reset: got %b %b %b %h expected 0 0 0 00", ro_activate, busy, done, out);
    else passes++;
    #4;
    rst_n = 1;
    samp[0] = therm(5);
    run_meas(7, 0);
    checks++;
    if (tmo || lat != SAMPLE_CYC + 1) $display("FAIL post_reset_latency: got %0d expected %0d", lat, SAMPLE_CYC + 1);
    else passes++;
    read_all();
    checks++;
    if (rd_avg !== 8'h05 || rd_st !== 8'h00) $display("FAIL post_reset_result: got avg %h st %h expected 05 00", rd_avg, rd_st);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_bubble();
    test_abort();
    test_ignore();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
